// File: rtl/mux4to1_v2_if.sv
// mux4to1_v2_if: bundles the data/select/enable inputs and the mux outputs.
//   data  [4*WIDTH] four packed lanes, lane 0 in the leftmost WIDTH bits
//   ss    [2]       lane select
//   en              capture enable for the registered path
//   ww    [WIDTH]   combinational mux output
//   ww_q  [WIDTH]   registered mux output
//   vld             ww_q holds a value captured under en
// master: the driver of data/ss/en. slave: the mux itself.
interface mux4to1_v2_if #(
  parameter int WIDTH = 1
);
  logic [4*WIDTH-1:0] data;
  logic [1:0]         ss;
  logic               en;
  logic [WIDTH-1:0]   ww;
  logic [WIDTH-1:0]   ww_q;
  logic               vld;

  modport master (output data, ss, en, input ww, ww_q, vld);
  modport slave  (input data, ss, en, output ww, ww_q, vld);
endinterface

// File: rtl/mux4to1_v2.sv
// mux4to1_v2: 4:1 lane mux with a combinational output and an
// enable-gated registered copy.
//   clk    sole clock, rising edge
//   rst_n  async active-low reset; clears ww_q and vld
//   bus    mux4to1_v2_if.slave (data, ss, en in; ww, ww_q, vld out)
// WIDTH must match the WIDTH of the connected interface (1..64).
module mux4to1_v2 #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mux4to1_v2_if.slave  bus
);

  // Ascending lane index so lanes[0] lands on the leftmost WIDTH bits of data.
  logic [0:3][WIDTH-1:0] lanes;
  logic [WIDTH-1:0]      ww;
  logic [WIDTH-1:0]      ww_q;
  logic                  vld;

  assign lanes = bus.data;
  // An unknown select makes the indexed read return X, as does an X lane.
  assign ww    = lanes[bus.ss];

  // Reset clears immediately; release is seen at the very next rising edge,
  // so the first capture happens on that edge when en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ww_q <= '0;
      vld  <= 1'b0;
    end else if (bus.en) begin
      ww_q <= ww;
      vld  <= 1'b1;
    end
  end

  assign bus.ww   = ww;
  assign bus.ww_q = ww_q;
  assign bus.vld  = vld;

endmodule

// File: tb/tb_mux4to1_v2.sv
module tb_mux4to1_v2;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  mux4to1_v2_if #(.WIDTH(1)) b1 ();
  mux4to1_v2_if #(.WIDTH(8)) b8 ();

  mux4to1_v2 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  mux4to1_v2 #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    b1.data = 4'b0000; b1.ss = 2'd0; b1.en = 1'b0;
    b8.data = 32'h0;   b8.ss = 2'd0; b8.en = 1'b0;

    // reset state and ww following the select while in reset
    #5;
    chk("rst_wwq", 64'(b1.ww_q), 64'h0);
    chk("rst_vld", 64'(b1.vld), 64'h0);
    b1.data = 4'b1000;
    #3;
    chk("rst_ww_follow", 64'(b1.ww), 64'h1);

    @(negedge clk);
    rst_n   = 1'b1;
    b1.data = 4'b0000;

    // combinational lane mapping, each step held >= 61 ns
    b1.ss = 2'b00; b1.data = 4'b0001; #30; chk("ss0_d0001", 64'(b1.ww), 64'h0); #31;
    b1.data = 4'b1000;                #30; chk("ss0_d1000", 64'(b1.ww), 64'h1); #31;
    b1.ss = 2'b10; b1.data = 4'b0100; #30; chk("ss2_d0100", 64'(b1.ww), 64'h0); #31;
    b1.data = 4'b0010;                #30; chk("ss2_d0010", 64'(b1.ww), 64'h1); #31;
    b1.ss = 2'b01; b1.data = 4'b0010; #30; chk("ss1_d0010", 64'(b1.ww), 64'h0); #31;
    b1.data = 4'b0110;                #30; chk("ss1_d0110", 64'(b1.ww), 64'h1); #31;
    b1.ss = 2'b11; b1.data = 4'b0110; #30; chk("ss3_d0110", 64'(b1.ww), 64'h0); #31;
    b1.data = 4'b0101;                #30; chk("ss3_d0101", 64'(b1.ww), 64'h1); #31;
    // combinational path ignores en and no edge has captured yet
    chk("no_cap_en0_wwq", 64'(b1.ww_q), 64'h0);
    chk("no_cap_en0_vld", 64'(b1.vld), 64'h0);

    // registered capture
    @(negedge clk);
    b1.ss = 2'b00; b1.data = 4'b1000; b1.en = 1'b1;
    @(negedge clk);
    chk("cap_wwq", 64'(b1.ww_q), 64'h1);
    chk("cap_vld", 64'(b1.vld), 64'h1);
    b1.en = 1'b0; b1.data = 4'b0000;
    repeat (3) @(negedge clk);
    chk("hold_wwq", 64'(b1.ww_q), 64'h1);
    chk("hold_vld", 64'(b1.vld), 64'h1);
    chk("hold_ww", 64'(b1.ww), 64'h0);

    // reset mid-cycle, then capture on the first edge after release
    #3;
    rst_n = 1'b0;
    #2;
    chk("async_rst_wwq", 64'(b1.ww_q), 64'h0);
    chk("async_rst_vld", 64'(b1.vld), 64'h0);
    b1.en = 1'b1; b1.ss = 2'b11; b1.data = 4'b0101;
    @(negedge clk);
    chk("rst_prio_wwq", 64'(b1.ww_q), 64'h0);
    chk("rst_prio_vld", 64'(b1.vld), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_wwq", 64'(b1.ww_q), 64'h1);
    chk("post_rst_vld", 64'(b1.vld), 64'h1);
    b1.en = 1'b0;

    // WIDTH=8 lane sweep
    b8.data = 32'hAABBCCDD;
    b8.ss = 2'd0; #5; chk("w8_ss0", 64'(b8.ww), 64'hAA);
    b8.ss = 2'd1; #5; chk("w8_ss1", 64'(b8.ww), 64'hBB);
    b8.ss = 2'd2; #5; chk("w8_ss2", 64'(b8.ww), 64'hCC);
    b8.ss = 2'd3; #5; chk("w8_ss3", 64'(b8.ww), 64'hDD);
    chk("w8_wwq_idle", 64'(b8.ww_q), 64'h0);
    @(negedge clk);
    b8.ss = 2'd2; b8.en = 1'b1;
    @(negedge clk);
    chk("w8_cap_wwq", 64'(b8.ww_q), 64'hCC);
    chk("w8_cap_vld", 64'(b8.vld), 64'h1);
    b8.en = 1'b0; b8.ss = 2'd1;
    @(negedge clk);
    chk("w8_hold_wwq", 64'(b8.ww_q), 64'hCC);
    chk("w8_ww_new", 64'(b8.ww), 64'hBB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
